dsp_pipe_ctrl: RTL and testbench

//   Valid/ready sequencer for a STAGES-deep chain of flop registers in the DSP datapath.

---
 rtl/dsp_pipe_ctrl.sv | 104 ++++++++++
 tb/tb_dsp_pipe_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pipe_ctrl.sv
// Valid/ready sequencer for a STAGES-deep chain of datapath registers: per-stage valid bits,
// load enables, bubble collapse, occupancy and flush. Optional stall counter: DSP_PIPE_CTRL_PERF_EN.
module dsp_pipe_ctrl #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 4
`ifdef DSP_PIPE_CTRL_PERF_EN
    ,
    parameter int PERF_W = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_vld,
    output logic [CNT_W-1:0]  occupancy,
    output logic              busy
`ifdef DSP_PIPE_CTRL_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [PERF_W-1:0] stall_cnt
`endif
);

    // Handshake: a word moves across a boundary on a cycle where the sender's valid and the
    // receiver's ready are both high; valid never depends on ready, ready may depend on valid.

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] src;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              accept;
    logic              deliver;

    // A stage can take a word unless it and every stage after it are full and the output is stalled.
    always_comb begin : ready_chain
        logic full_above;
        full_above = 1'b1;
        rdy        = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            full_above = full_above & v_q[i];
            rdy[i]     = ~full_above | out_ready;
        end
    end

    always_comb begin
        in_ready = rdy[0] & ~flush & ~reset;
        accept   = in_valid & in_ready;
        deliver  = v_q[STAGES-1] & out_ready;
        src      = {v_q[STAGES-2:0], accept};
        stage_en = rdy & src & {STAGES{~flush}};

        v_d   = (rdy & src) | (~rdy & v_q);
        occ_d = occ_q + CNT_W'(accept) - CNT_W'(deliver);
        if (flush) begin
            v_d   = '0;
            occ_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign stage_vld = v_q;
    assign occupancy = occ_q;
    assign busy      = |v_q;

`ifdef DSP_PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_q, stall_d;

    // Clear wins over increment; the count sticks at all-ones once reached.
    always_comb begin
        stall_d = stall_q;
        if (perf_clr) begin
            stall_d = '0;
        end else if (v_q[STAGES-1] && !out_ready && !(&stall_q)) begin
            stall_d = stall_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// Directed bench for dsp_pipe_ctrl (STAGES=4): streaming, back-pressure, bubble collapse,
// flush, async reset, and the stall counter when DSP_PIPE_CTRL_PERF_EN is defined.
module tb_dsp_pipe_ctrl;

    localparam int STAGES = 4;
    localparam int CNT_W  = 4;
`ifdef DSP_PIPE_CTRL_PERF_EN
    localparam int PERF_W = 4;
`endif

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              flush;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_vld;
    logic [CNT_W-1:0]  occupancy;
    logic              busy;
`ifdef DSP_PIPE_CTRL_PERF_EN
    logic              perf_clr;
    logic [PERF_W-1:0] stall_cnt;
`endif

    int         n_assert = 0;
    int         n_fail   = 0;
    int         n_acc    = 0;
    logic [7:0] in_data;
    logic [7:0] dp [STAGES];
    logic [7:0] exp_q [$];

    dsp_pipe_ctrl #(
        .STAGES(STAGES),
        .CNT_W (CNT_W)
`ifdef DSP_PIPE_CTRL_PERF_EN
        ,
        .PERF_W(PERF_W)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .flush    (flush),
        .stage_en (stage_en),
        .stage_vld(stage_vld),
        .occupancy(occupancy),
        .busy     (busy)
`ifdef DSP_PIPE_CTRL_PERF_EN
        ,
        .perf_clr (perf_clr),
        .stall_cnt(stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data registers loaded only by the controller's enables.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (stage_en[i]) dp[i] <= (i == 0) ? in_data : dp[i-1];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: score handshakes seen before the edge, then settle 1 time unit after it.
    task automatic tick();
        logic       acc;
        logic       del;
        logic [7:0] w;
        acc = in_valid & in_ready;
        del = out_valid & out_ready;
        w   = dp[STAGES-1];
        if (del) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check("sb_data", {24'd0, w}, {24'd0, exp_q.pop_front()});
        end
        if (acc) begin
            exp_q.push_back(in_data);
            n_acc++;
        end
        if (flush) exp_q.delete();
        @(posedge clk);
        #1;
        if (acc) in_data = in_data + 8'd1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_data   = 8'h10;
`ifdef DSP_PIPE_CTRL_PERF_EN
        perf_clr  = 1'b0;
`endif
        #2;
        check("rst_stage_vld", 32'(stage_vld), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_stage_en", 32'(stage_en), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef DSP_PIPE_CTRL_PERF_EN
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Free-running stream
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t1_in_ready", 32'(in_ready), 32'd1);
        check("t1_en_first", 32'(stage_en), 32'b0001);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("t1_out_valid_e%0d", c), 32'(out_valid), (c == 4) ? 32'd1 : 32'd0);
        end
        check("t1_en_steady", 32'(stage_en), 32'b1111);
        check("t1_occ_full", 32'(occupancy), 32'd4);
        check("t1_in_ready_full", 32'(in_ready), 32'd1);
        repeat (6) tick();
        check("t1_occ_steady", 32'(occupancy), 32'd4);
        in_valid = 1'b0;
        repeat (4) tick();
        check("t1_occ_drained", 32'(occupancy), 32'd0);
        check("t1_busy_drained", 32'(busy), 32'd0);
        check("t1_all_delivered", 32'(exp_q.size()), 32'd0);

        // Back-pressure fills the pipe, then releasing out_ready opens in_ready combinationally
        n_acc     = 0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        repeat (6) tick();
        check("t2_accepts", 32'(n_acc), 32'd4);
        check("t2_occ", 32'(occupancy), 32'd4);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        check("t2_stage_en", 32'(stage_en), 32'd0);
        check("t2_stage_vld", 32'(stage_vld), 32'b1111);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t2_in_ready_release", 32'(in_ready), 32'd1);
        repeat (4) tick();
        check("t2_occ_drained", 32'(occupancy), 32'd0);

        // Bubble collapse behind a stalled output
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("t3_single_at_out", 32'(stage_vld), 32'b1000);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t3_in_ready_%0d", c), 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        check("t3_stage_vld", 32'(stage_vld), 32'b1111);
        check("t3_occ", 32'(occupancy), 32'd4);
        check("t3_in_ready_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        check("t3_busy_drained", 32'(busy), 32'd0);

        // Flush with occupancy 3, flush over a pending accept, and flush during a delivery
        in_valid  = 1'b1;
        out_ready = 1'b0;
        repeat (3) tick();
        check("t4_occ3", 32'(occupancy), 32'd3);
        check("t4_vld3", 32'(stage_vld), 32'b0111);
        flush = 1'b1;
        #1;
        check("t4_flush_in_ready", 32'(in_ready), 32'd0);
        check("t4_flush_stage_en", 32'(stage_en), 32'd0);
        tick();
        check("t4_vld_after", 32'(stage_vld), 32'd0);
        check("t4_occ_after", 32'(occupancy), 32'd0);
        check("t4_out_valid_after", 32'(out_valid), 32'd0);
        repeat (2) tick();
        check("t4_flush_hold", 32'(stage_vld), 32'd0);
        flush = 1'b0;
        repeat (4) tick();
        check("t4_refill", 32'(occupancy), 32'd4);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t4_flush_out_valid", 32'(out_valid), 32'd1);
        tick();
        check("t4_flush_deliver_occ", 32'(occupancy), 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;

        // Asynchronous reset mid-stream, then a clean restart
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("t5_occ_pre", 32'(occupancy), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t5_vld_async", 32'(stage_vld), 32'd0);
        check("t5_occ_async", 32'(occupancy), 32'd0);
        check("t5_out_valid_async", 32'(out_valid), 32'd0);
        check("t5_in_ready_async", 32'(in_ready), 32'd0);
        check("t5_stage_en_async", 32'(stage_en), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_in_ready_restart", 32'(in_ready), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("t5_out_valid_e%0d", c), 32'(out_valid), (c == 4) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check("t5_occ_drained", 32'(occupancy), 32'd0);
        check("t5_all_delivered", 32'(exp_q.size()), 32'd0);

`ifdef DSP_PIPE_CTRL_PERF_EN
        // Stall counter saturation and clear
        perf_clr  = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("t6_out_valid", 32'(out_valid), 32'd1);
        check("t6_cleared", 32'(stall_cnt), 32'd0);
        perf_clr = 1'b0;
        repeat (5) tick();
        check("t6_cnt5", 32'(stall_cnt), 32'd5);
        repeat (15) tick();
        check("t6_saturated", 32'(stall_cnt), 32'd15);
        perf_clr = 1'b1;
        tick();
        check("t6_clr", 32'(stall_cnt), 32'd0);
        perf_clr  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t6_no_stall", 32'(stall_cnt), 32'd0);
        check("t6_busy_drained", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
